// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: forward-select encodings,
// divider state encoding and a saturating-increment helper.
package hazard_ctrl_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_WB = 2'b01;
   localparam logic [1:0] FWD_MS = 2'b10;
   localparam logic [1:0] FWD_ES = 2'b11;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_DONE = 2'b10
   } div_state_e;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      logic [31:0] r;
      if (v == 32'hFFFF_FFFF) begin
         r = v;
      end else begin
         r = v + 32'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-source forwarding priority encoder: EXE > MEM > WB > regfile.
// Register $0 never forwards.
module fwd_sel
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0] src_addr,
   input  logic       es_valid,
   input  logic       es_gr_we,
   input  logic [4:0] es_dest,
   input  logic       ms_valid,
   input  logic       ms_gr_we,
   input  logic [4:0] ms_dest,
   input  logic       ws_valid,
   input  logic       ws_gr_we,
   input  logic [4:0] ws_dest,
   output logic [1:0] sel
);

   logic nz_s;
   logic hit_e_s;
   logic hit_m_s;
   logic hit_w_s;

   assign nz_s    = (src_addr != 5'd0);
   assign hit_e_s = es_valid & es_gr_we & (es_dest == src_addr) & nz_s;
   assign hit_m_s = ms_valid & ms_gr_we & (ms_dest == src_addr) & nz_s;
   assign hit_w_s = ws_valid & ws_gr_we & (ws_dest == src_addr) & nz_s;

   // priority select of the youngest producing stage
   always_comb begin
      sel = FWD_RF;
      if (hit_e_s) begin
         sel = FWD_ES;
      end else if (hit_m_s) begin
         sel = FWD_MS;
      end else if (hit_w_s) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_RF;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode hazard controller: forwarding selects, load-use and HI/LO stalls,
// multi-cycle divider sequencing and a saturating stall-cycle counter.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = 33,
   parameter int CNT_W      = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ds_use_rs,
   input  logic        ds_use_rt,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   input  logic        ds_hilo_use,
   input  logic        es_valid,
   input  logic        es_gr_we,
   input  logic [4:0]  es_dest,
   input  logic        es_load,
   input  logic        ms_valid,
   input  logic        ms_gr_we,
   input  logic [4:0]  ms_dest,
   input  logic        ws_valid,
   input  logic        ws_gr_we,
   input  logic [4:0]  ws_dest,
   input  logic        es_div_start,
   output logic [1:0]  forward_rs,
   output logic [1:0]  forward_rt,
   output logic        stallD,
   output logic        es_div_busy,
   output logic        es_div_done,
   output logic [31:0] stall_cnt
);

   // The start cycle counts as one, and BUSY exits on the cycle cnt reads zero.
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV_CYCLES - 2);

   div_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q;
   logic [31:0]      stall_cnt_q;
   logic [31:0]      stall_cnt_d;
   logic             luse_s;
   logic             hilo_stall_s;

   fwd_sel u_fwd_rs (
      .src_addr (rs_addr),
      .es_valid (es_valid), .es_gr_we (es_gr_we), .es_dest (es_dest),
      .ms_valid (ms_valid), .ms_gr_we (ms_gr_we), .ms_dest (ms_dest),
      .ws_valid (ws_valid), .ws_gr_we (ws_gr_we), .ws_dest (ws_dest),
      .sel      (forward_rs)
   );

   fwd_sel u_fwd_rt (
      .src_addr (rt_addr),
      .es_valid (es_valid), .es_gr_we (es_gr_we), .es_dest (es_dest),
      .ms_valid (ms_valid), .ms_gr_we (ms_gr_we), .ms_dest (ms_dest),
      .ws_valid (ws_valid), .ws_gr_we (ws_gr_we), .ws_dest (ws_dest),
      .sel      (forward_rt)
   );

   // An EXE-select is exactly an EXE hit, so the encoder output doubles as hitE.
   assign luse_s = es_load & ((ds_use_rs & (forward_rs == FWD_ES)) |
                              (ds_use_rt & (forward_rt == FWD_ES)));
   assign hilo_stall_s = ds_hilo_use & ((state_q != DIV_IDLE) | es_div_start);
   assign stallD       = luse_s | hilo_stall_s;
   assign es_div_busy  = es_div_start | (state_q == DIV_BUSY);
   assign es_div_done  = done_q;
   assign stall_cnt    = stall_cnt_q;

   // saturating stall-cycle count
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stallD) begin
         stall_cnt_d = sat_inc32(stall_cnt_q);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // divider sequencer and counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= DIV_IDLE;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         case (state_q)
            DIV_IDLE: begin
               done_q <= 1'b0;
               if (es_div_start) begin
                  state_q <= DIV_BUSY;
                  cnt_q   <= CNT_RELOAD;
               end else begin
                  state_q <= DIV_IDLE;
               end
            end
            DIV_BUSY: begin
               if (cnt_q == '0) begin
                  state_q <= DIV_DONE;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q - CNT_W'(1);
                  done_q  <= 1'b0;
               end
            end
            DIV_DONE: begin
               done_q <= 1'b0;
               if (es_div_start) begin
                  state_q <= DIV_BUSY;
                  cnt_q   <= CNT_RELOAD;
               end else begin
                  state_q <= DIV_IDLE;
               end
            end
            default: begin
               state_q <= DIV_IDLE;
               cnt_q   <= '0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a cycle-level reference model checked
// every cycle on the falling edge, plus directed scenarios with literal expectations.
module tb_hazard_ctrl;

   localparam int DIV_CYCLES = 33;

   logic        clk = 1'b0;
   logic        reset;
   logic        ds_use_rs, ds_use_rt, ds_hilo_use;
   logic [4:0]  rs_addr, rt_addr;
   logic        es_valid, es_gr_we, es_load;
   logic [4:0]  es_dest;
   logic        ms_valid, ms_gr_we;
   logic [4:0]  ms_dest;
   logic        ws_valid, ws_gr_we;
   logic [4:0]  ws_dest;
   logic        es_div_start;
   logic [1:0]  forward_rs, forward_rt;
   logic        stallD, es_div_busy, es_div_done;
   logic [31:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) dut (
      .clk(clk), .reset(reset),
      .ds_use_rs(ds_use_rs), .ds_use_rt(ds_use_rt),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .ds_hilo_use(ds_hilo_use),
      .es_valid(es_valid), .es_gr_we(es_gr_we), .es_dest(es_dest), .es_load(es_load),
      .ms_valid(ms_valid), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
      .ws_valid(ws_valid), .ws_gr_we(ws_gr_we), .ws_dest(ws_dest),
      .es_div_start(es_div_start),
      .forward_rs(forward_rs), .forward_rt(forward_rt), .stallD(stallD),
      .es_div_busy(es_div_busy), .es_div_done(es_div_done), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int          cyc    = 0;
   int          div_s  = 0;
   bit          div_on = 1'b0;
   bit          armed  = 1'b0;
   logic [31:0] m_cnt  = 32'd0;

   function automatic logic [1:0] ref_fwd(input logic [4:0] a);
      if (a == 5'd0) return 2'd0;
      if (es_valid && es_gr_we && es_dest == a) return 2'd3;
      if (ms_valid && ms_gr_we && ms_dest == a) return 2'd2;
      if (ws_valid && ws_gr_we && ws_dest == a) return 2'd1;
      return 2'd0;
   endfunction

   int   m_age;
   logic m_in_busy, m_busy, m_done, m_luse, m_stall;
   logic [1:0] m_frs, m_frt;

   always_comb begin
      m_age     = cyc - div_s;
      m_in_busy = div_on && m_age >= 1 && m_age <= DIV_CYCLES - 1;
      m_busy    = es_div_start | m_in_busy;
      m_done    = div_on && m_age == DIV_CYCLES;
      m_frs     = ref_fwd(rs_addr);
      m_frt     = ref_fwd(rt_addr);
      m_luse    = es_load && ((ds_use_rs && m_frs == 2'd3) || (ds_use_rt && m_frt == 2'd3));
      m_stall   = m_luse || (ds_hilo_use && (es_div_start || (div_on && m_age >= 1)));
   end

   // advance the model on each rising edge
   always @(posedge clk) begin
      if (armed && !reset && es_div_start && m_in_busy) begin
         bad   <= bad + 1;
         $display("FAIL proto: es_div_start=1 while divider busy at cycle %0d", cyc);
      end
      if (reset) begin
         div_on <= 1'b0;
         m_cnt  <= 32'd0;
         armed  <= 1'b1;
      end else begin
         if (m_stall && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
         if (es_div_start && !m_in_busy) begin
            div_on <= 1'b1;
            div_s  <= cyc;
         end else if (m_done) begin
            div_on <= 1'b0;
         end
      end
      cyc <= cyc + 1;
   end

   // compare every cycle on the falling edge
   always @(negedge clk) begin
      if (armed) begin
         total = total + 6;
         if (forward_rs !== m_frs) begin bad = bad + 1; $display("FAIL cyc%0d forward_rs got %b want %b", cyc, forward_rs, m_frs); end
         if (forward_rt !== m_frt) begin bad = bad + 1; $display("FAIL cyc%0d forward_rt got %b want %b", cyc, forward_rt, m_frt); end
         if (stallD !== m_stall) begin bad = bad + 1; $display("FAIL cyc%0d stallD got %b want %b", cyc, stallD, m_stall); end
         if (es_div_busy !== m_busy) begin bad = bad + 1; $display("FAIL cyc%0d es_div_busy got %b want %b", cyc, es_div_busy, m_busy); end
         if (es_div_done !== m_done) begin bad = bad + 1; $display("FAIL cyc%0d es_div_done got %b want %b", cyc, es_div_done, m_done); end
         if (stall_cnt !== m_cnt) begin bad = bad + 1; $display("FAIL cyc%0d stall_cnt got %0d want %0d", cyc, stall_cnt, m_cnt); end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ds_use_rs = 1'b0; ds_use_rt = 1'b0; ds_hilo_use = 1'b0;
      rs_addr = 5'd0; rt_addr = 5'd0;
      es_valid = 1'b0; es_gr_we = 1'b0; es_load = 1'b0; es_dest = 5'd0;
      ms_valid = 1'b0; ms_gr_we = 1'b0; ms_dest = 5'd0;
      ws_valid = 1'b0; ws_gr_we = 1'b0; ws_dest = 5'd0;
      es_div_start = 1'b0;
   endtask

   int          t0;
   int          done1;
   int          done2;
   int          npulse;
   logic [31:0] c0;

   initial begin
      clear_inputs();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      #2;
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      chk("rst_done", {31'd0, es_div_done}, 32'd0);
      chk("rst_busy", {31'd0, es_div_busy}, 32'd0);
      chk("rst_stallD", {31'd0, stallD}, 32'd0);
      chk("rst_fwd", {28'd0, forward_rs, forward_rt}, 32'd0);
      tick();

      // forward priority
      es_valid = 1'b1; es_gr_we = 1'b1; es_dest = 5'd5;
      ms_valid = 1'b1; ms_gr_we = 1'b1; ms_dest = 5'd5;
      ws_valid = 1'b1; ws_gr_we = 1'b1; ws_dest = 5'd5;
      rs_addr = 5'd5; ds_use_rs = 1'b1;
      #2; chk("fwd_es", {30'd0, forward_rs}, 32'd3); tick();
      es_valid = 1'b0;
      #2; chk("fwd_ms", {30'd0, forward_rs}, 32'd2); tick();
      ms_valid = 1'b0;
      #2; chk("fwd_wb", {30'd0, forward_rs}, 32'd1); tick();
      ws_valid = 1'b0;
      #2; chk("fwd_rf", {30'd0, forward_rs}, 32'd0); tick();

      // $0 never forwards
      es_valid = 1'b1; ms_valid = 1'b1; ws_valid = 1'b1;
      es_dest = 5'd0; ms_dest = 5'd0; ws_dest = 5'd0; es_load = 1'b1;
      rs_addr = 5'd0; rt_addr = 5'd0; ds_use_rt = 1'b1;
      #2;
      chk("r0_fwd", {28'd0, forward_rs, forward_rt}, 32'd0);
      chk("r0_stall", {31'd0, stallD}, 32'd0);
      tick();
      clear_inputs();

      // load-use, then the load moves to MEM
      es_valid = 1'b1; es_gr_we = 1'b1; es_load = 1'b1; es_dest = 5'd8;
      ms_valid = 1'b1; ms_gr_we = 1'b1; ms_dest = 5'd8;
      rt_addr = 5'd8; ds_use_rt = 1'b1;
      c0 = stall_cnt;
      #2; chk("luse_stall", {31'd0, stallD}, 32'd1); tick();
      es_valid = 1'b0; es_load = 1'b0;
      #2;
      chk("luse_cnt", stall_cnt - c0, 32'd1);
      chk("luse_clear", {31'd0, stallD}, 32'd0);
      chk("luse_fwd_ms", {30'd0, forward_rt}, 32'd2);
      tick();
      clear_inputs();

      // single divide with HI/LO consumer held in decode
      ds_hilo_use = 1'b1; es_div_start = 1'b1; t0 = cyc; done1 = -1;
      for (int k = 0; k <= 40; k++) begin
         if (k == 5) begin
            es_valid = 1'b1; es_gr_we = 1'b1; es_load = 1'b1; es_dest = 5'd9;
            rt_addr = 5'd9; ds_use_rt = 1'b1; c0 = stall_cnt;
         end
         if (k == 6) begin
            es_valid = 1'b0; es_load = 1'b0; ds_use_rt = 1'b0;
            chk("dual_stall_one", stall_cnt - c0, 32'd1);
         end
         #2;
         if (k == 0)  chk("div_busy_T", {31'd0, es_div_busy}, 32'd1);
         if (k == 32) chk("div_busy_T32", {31'd0, es_div_busy}, 32'd1);
         if (k == 33) begin
            chk("div_busy_T33", {31'd0, es_div_busy}, 32'd0);
            chk("div_stall_T33", {31'd0, stallD}, 32'd1);
         end
         if (k == 34) chk("div_stall_T34", {31'd0, stallD}, 32'd0);
         if (es_div_done && done1 < 0) done1 = cyc - t0;
         tick();
         es_div_start = 1'b0;
      end
      chk("div_done_lat", 32'(done1), 32'd33);
      clear_inputs();

      // back-to-back divides
      es_div_start = 1'b1; t0 = cyc; done1 = -1; done2 = -1;
      for (int k = 0; k <= 80; k++) begin
         es_div_start = (k == 0 || k == 33);
         #2;
         if (k == 33) chk("b2b_busy_in_done", {31'd0, es_div_busy}, 32'd1);
         if (es_div_done) begin
            if (done1 < 0) done1 = cyc - t0;
            else if (done2 < 0) done2 = cyc - t0;
         end
         tick();
      end
      es_div_start = 1'b0;
      chk("b2b_done1", 32'(done1), 32'd33);
      chk("b2b_done2", 32'(done2), 32'd66);

      // reset in the middle of a divide
      ds_hilo_use = 1'b1; es_div_start = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         es_div_start = 1'b0;
      end
      reset = 1'b1; ds_hilo_use = 1'b0;
      tick();
      reset = 1'b0;
      #2;
      chk("mid_rst_busy", {31'd0, es_div_busy}, 32'd0);
      chk("mid_rst_cnt", stall_cnt, 32'd0);
      npulse = 0;
      for (int k = 0; k < 40; k++) begin
         #2;
         if (es_div_done) npulse++;
         tick();
      end
      chk("mid_rst_no_done", 32'(npulse), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
